// File: rtl/guest_deadline_sequencer.sv
// Guest deadline sequencer: on every guest switch, adds the outgoing slice length to that
// guest's run time, checks it against the guest's deadline, and clears run times at frame end.
module guest_deadline_sequencer #(
    parameter int TIME_W = 32,
    parameter int GUESTS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [2:0]        current_guest,
    input  logic [TIME_W-1:0] current_time,
    input  logic              overflow,
    input  logic              finish,
    output logic              mem_en,
    output logic              mem_we,
    output logic [2:0]        mem_guest,
    output logic              mem_col,
    output logic [TIME_W-1:0] mem_wdata,
    input  logic [TIME_W-1:0] mem_rdata,
    output logic [2:0]        tdi_error,
    output logic [2:0]        error_guest,
    output logic              error_valid,
    output logic              busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD_DL  = 3'd1;
    localparam logic [2:0] RD_RT  = 3'd2;
    localparam logic [2:0] CALC   = 3'd3;
    localparam logic [2:0] WR_RT  = 3'd4;
    localparam logic [2:0] REPORT = 3'd5;
    localparam logic [2:0] CLEAR  = 3'd6;

    localparam logic [TIME_W-1:0] ALL_ONES   = '1;
    localparam logic [2:0]        LAST_GUEST = 3'(GUESTS - 1);

    logic [2:0]        state;
    logic [2:0]        prev_guest;
    logic [TIME_W-1:0] slice_start;
    logic [1:0]        ovf_cnt;
    logic              pend_valid, pend_first, pend_oerr;
    logic [2:0]        pend_guest;
    logic [TIME_W-1:0] pend_elapsed;
    logic              clear_req, drop_flag;
    logic [2:0]        job_guest;
    logic [TIME_W-1:0] job_elapsed;
    logic              job_oerr;
    logic [1:0]        job_err;
    logic [TIME_W-1:0] deadline_q, new_rt;
    logic [2:0]        clr_idx;

    logic              change, ovf_sat, run_clear, take_pend, take_new;
    logic              buffer_req, slot_free, drop_now, over;
    logic [TIME_W-1:0] ev_elapsed, rt_sat;
    logic [TIME_W:0]   rt_sum;

    // The overflow pulse of the switching cycle still belongs to the outgoing slice.
    assign change     = enable && (current_guest != prev_guest);
    assign ovf_sat    = (ovf_cnt == 2'd2) || ((ovf_cnt == 2'd1) && overflow);
    assign ev_elapsed = ovf_sat ? ALL_ONES : current_time - slice_start;

    // A clear yields only to a pending update that was buffered before the clear request.
    assign run_clear  = (state == IDLE) && clear_req && !(pend_valid && pend_first);
    assign take_pend  = (state == IDLE) && !run_clear && pend_valid;
    assign take_new   = (state == IDLE) && !run_clear && !pend_valid && change;
    assign buffer_req = change && !take_new;
    assign slot_free  = !pend_valid || take_pend;
    assign drop_now   = buffer_req && !slot_free;

    assign rt_sum = {1'b0, mem_rdata} + {1'b0, job_elapsed};
    assign rt_sat = rt_sum[TIME_W] ? ALL_ONES : rt_sum[TIME_W-1:0];
    assign over   = (deadline_q != '0) && (rt_sat > deadline_q);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_guest = '0;
        mem_col   = 1'b0;
        mem_wdata = '0;
        case (state)
            RD_DL: begin
                mem_en    = 1'b1;
                mem_guest = job_guest;
            end
            RD_RT: begin
                mem_en    = 1'b1;
                mem_guest = job_guest;
                mem_col   = 1'b1;
            end
            WR_RT: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_guest = job_guest;
                mem_col   = 1'b1;
                mem_wdata = new_rt;
            end
            CLEAR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_guest = clr_idx;
                mem_col   = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy        = (state != IDLE);
    assign error_valid = (state == REPORT) && (tdi_error != 3'b000);

    // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            prev_guest   <= '0;
            slice_start  <= '0;
            ovf_cnt      <= '0;
            pend_valid   <= 1'b0;
            pend_first   <= 1'b0;
            pend_oerr    <= 1'b0;
            pend_guest   <= '0;
            pend_elapsed <= '0;
            clear_req    <= 1'b0;
            drop_flag    <= 1'b0;
            job_guest    <= '0;
            job_elapsed  <= '0;
            job_oerr     <= 1'b0;
            job_err      <= '0;
            deadline_q   <= '0;
            new_rt       <= '0;
            clr_idx      <= '0;
            tdi_error    <= '0;
            error_guest  <= '0;
        end else begin
            if (change) begin
                prev_guest  <= current_guest;
                slice_start <= current_time;
                ovf_cnt     <= '0;
            end else if (overflow && (ovf_cnt != 2'd2)) begin
                ovf_cnt <= ovf_cnt + 2'd1;
            end

            if (buffer_req && slot_free) begin
                pend_valid   <= 1'b1;
                pend_first   <= !clear_req;
                pend_guest   <= prev_guest;
                pend_elapsed <= ev_elapsed;
                pend_oerr    <= ovf_sat;
            end else if (take_pend) begin
                pend_valid <= 1'b0;
            end

            if (run_clear)
                clear_req <= 1'b0;
            else if (finish && (state != CLEAR))
                clear_req <= 1'b1;

            if (state == WR_RT)
                drop_flag <= 1'b0;
            else if (drop_now)
                drop_flag <= 1'b1;

            case (state)
                IDLE: begin
                    if (run_clear) begin
                        clr_idx <= '0;
                        state   <= CLEAR;
                    end else if (take_pend) begin
                        job_guest   <= pend_guest;
                        job_elapsed <= pend_elapsed;
                        job_oerr    <= pend_oerr;
                        state       <= RD_DL;
                    end else if (take_new) begin
                        job_guest   <= prev_guest;
                        job_elapsed <= ev_elapsed;
                        job_oerr    <= ovf_sat;
                        state       <= RD_DL;
                    end
                end
                RD_DL:  state <= RD_RT;
                RD_RT: begin
                    deadline_q <= mem_rdata;
                    state      <= CALC;
                end
                CALC: begin
                    new_rt  <= rt_sat;
                    job_err <= {job_oerr, over};
                    state   <= WR_RT;
                end
                WR_RT: begin
                    tdi_error <= {drop_flag | drop_now, job_err};
                    if (drop_flag || drop_now || (job_err != 2'b00))
                        error_guest <= job_guest;
                    state <= REPORT;
                end
                REPORT: state <= IDLE;
                CLEAR: begin
                    clr_idx <= clr_idx + 3'd1;
                    if (clr_idx == LAST_GUEST)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
